// File: rtl/jtcps1_gfx_romreq.sv
// jtcps1_gfx_romreq
// Turns one tile-row fetch request into a graphics ROM read. The tile code is
// first presented to the bank mapper, the mapper's registered offset/mask
// result builds the ROM word address, and the SDRAM cs/ok handshake returns
// 32 bits of pixel data. Codes the mapper reports as unmapped return blank
// data without an SDRAM access. A one-entry cache replays the last completed
// request (star-layer requests are never cached).
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req/layer/code/sub    request strobe and its fields (sampled while idle)
//   busy                  request in flight
//   data_ok/data/blank    one-cycle completion pulse, data and blank flag
//   map_enable/map_layer/map_cin      query to the bank mapper
//   map_offset/map_mask/map_unmapped  mapper result, MAP_LAT cycles later
//   rom_addr/rom_cs/rom_ok/rom_data   SDRAM graphics port
//   timeout               sticky watchdog flag
//
// Build option
//   JTCPS1_GFX_TIMEOUT_EN  adds a FETCH watchdog of TIMEOUT cycles. When left
//                          undefined FETCH waits forever and timeout is 0.

module jtcps1_gfx_romreq #(
    parameter int AW      = 22,
    parameter int MAP_LAT = 2,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req,
    input  logic [2:0]    layer,
    input  logic [15:0]   code,
    input  logic [5:0]    sub,
    output logic          busy,
    output logic          data_ok,
    output logic [31:0]   data,
    output logic          blank,
    output logic          map_enable,
    output logic [2:0]    map_layer,
    output logic [9:0]    map_cin,
    input  logic [3:0]    map_offset,
    input  logic [3:0]    map_mask,
    input  logic          map_unmapped,
    output logic [AW-1:0] rom_addr,
    output logic          rom_cs,
    input  logic          rom_ok,
    input  logic [31:0]   rom_data,
    output logic          timeout
);

    localparam logic [2:0] STARS = 3'd4;
    localparam int         CW    = (MAP_LAT < 2) ? 1 : $clog2(MAP_LAT + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HIT   = 3'd1,
        MAP   = 3'd2,
        FETCH = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t state_q, state_d;

    // Latched request
    logic [2:0]  layer_q;
    logic [15:0] code_q;
    logic [5:0]  sub_q;

    logic [CW-1:0] map_cnt;

    // One-entry result cache
    logic        cache_valid;
    logic [24:0] cache_tag;
    logic [31:0] cache_data;
    logic        cache_blank;

    logic        hit;
    logic        expire;     // watchdog fired this cycle
    logic        fetch_fail; // current result came from the watchdog
    logic [3:0]  mapped_hi;

    assign hit = cache_valid && (layer != STARS) &&
                 (cache_tag == {layer, code, sub});

    assign mapped_hi = (code_q[15:12] & map_mask) | map_offset;

    assign busy    = (state_q != IDLE);
    assign data_ok = (state_q == DONE);

`ifdef JTCPS1_GFX_TIMEOUT_EN
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [TW-1:0] to_cnt;
    logic          timeout_q;
    logic          fail_q;

    // rom_ok in the last allowed cycle still wins over the watchdog
    assign expire     = (state_q == FETCH) && !rom_ok &&
                        (to_cnt == TW'(TIMEOUT - 1));
    assign fetch_fail = fail_q;
    assign timeout    = timeout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt    <= '0;
            timeout_q <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            if (state_q != FETCH) to_cnt <= '0;
            else                  to_cnt <= to_cnt + 1'b1;
            if (expire) begin
                timeout_q <= 1'b1;
                fail_q    <= 1'b1;
            end else if (state_q == IDLE && req) begin
                fail_q    <= 1'b0;
            end
        end
    end
`else
    assign expire     = 1'b0;
    assign fetch_fail = 1'b0;
    // TIMEOUT only has meaning with the watchdog built in
    assign timeout    = 1'b0 && (TIMEOUT > 0);
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (req) state_d = hit ? HIT : MAP;
            HIT:   state_d = DONE;
            MAP:   if (map_cnt == '0) state_d = map_unmapped ? DONE : FETCH;
            FETCH: if (rom_ok || expire) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            layer_q     <= '0;
            code_q      <= '0;
            sub_q       <= '0;
            map_cnt     <= '0;
            map_enable  <= 1'b0;
            map_layer   <= '0;
            map_cin     <= '0;
            rom_addr    <= '0;
            rom_cs      <= 1'b0;
            data        <= '0;
            blank       <= 1'b0;
            cache_valid <= 1'b0;
            cache_tag   <= '0;
            cache_data  <= '0;
            cache_blank <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (req) begin
                    layer_q <= layer;
                    code_q  <= code;
                    sub_q   <= sub;
                    if (!hit) begin
                        map_layer  <= layer;
                        map_cin    <= code[15:6];
                        map_enable <= 1'b1;
                        map_cnt    <= CW'(MAP_LAT);
                    end
                end
                HIT: begin
                    data  <= cache_data;
                    blank <= cache_blank;
                end
                MAP: begin
                    if (map_cnt != '0) begin
                        map_cnt <= map_cnt - 1'b1;
                    end else if (map_unmapped) begin
                        data  <= '0;
                        blank <= 1'b1;
                    end else begin
                        rom_addr <= AW'({mapped_hi, code_q[11:0], sub_q});
                        rom_cs   <= 1'b1;
                    end
                end
                FETCH: begin
                    if (rom_ok) begin
                        data   <= rom_data;
                        blank  <= 1'b0;
                        rom_cs <= 1'b0;
                    end else if (expire) begin
                        data   <= 32'hFFFF_FFFF;
                        blank  <= 1'b0;
                        rom_cs <= 1'b0;
                    end
                end
                DONE: begin
                    map_enable <= 1'b0;
                    // Star data is never replayed, and a watchdog result is
                    // not worth remembering either.
                    if (layer_q == STARS || fetch_fail) begin
                        cache_valid <= 1'b0;
                    end else begin
                        cache_valid <= 1'b1;
                        cache_tag   <= {layer_q, code_q, sub_q};
                        cache_data  <= data;
                        cache_blank <= blank;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_jtcps1_gfx_romreq.sv
// Directed bench for jtcps1_gfx_romreq. Stimulus pushes the expected
// completion (data, blank, cycle of data_ok) into a queue; a monitor on the
// falling edge pops and compares whenever data_ok is seen.

module tb_jtcps1_gfx_romreq;

`ifdef JTCPS1_GFX_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic [2:0]  layer;
    logic [15:0] code;
    logic [5:0]  sub;
    logic        busy, data_ok, blank, map_enable, rom_cs, rom_ok, timeout;
    logic [31:0] data, rom_data;
    logic [2:0]  map_layer;
    logic [9:0]  map_cin;
    logic [3:0]  map_offset, map_mask;
    logic        map_unmapped;
    logic [21:0] rom_addr;

    jtcps1_gfx_romreq #(.AW(22), .MAP_LAT(2), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .layer(layer), .code(code),
        .sub(sub), .busy(busy), .data_ok(data_ok), .data(data), .blank(blank),
        .map_enable(map_enable), .map_layer(map_layer), .map_cin(map_cin),
        .map_offset(map_offset), .map_mask(map_mask),
        .map_unmapped(map_unmapped), .rom_addr(rom_addr), .rom_cs(rom_cs),
        .rom_ok(rom_ok), .rom_data(rom_data), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Mapper model: two-register pipeline. Outside an enabled query it
    // presents an "unmapped" junk value so early sampling shows up.
    logic [3:0] cfg_off, cfg_mask;
    logic       cfg_unm;
    logic [8:0] p1, p2;
    always @(posedge clk) begin
        p1 <= map_enable ? {cfg_off, cfg_mask, cfg_unm} : 9'h1FF;
        p2 <= p1;
    end
    assign {map_offset, map_mask, map_unmapped} = p2;

    // Scoreboard
    typedef struct {
        logic [31:0] d;
        logic        b;
        int          at;
    } exp_t;
    exp_t sbq[$];
    int   t_req;
    bit   post_chk = 0;

    always @(negedge clk) begin
        exp_t e;
        if (post_chk) begin
            chk("busy_after_ok", busy, 0);
            post_chk = 0;
        end
        if (data_ok) begin
            if (sbq.size() == 0) begin
                chk("spurious_data_ok", 1, 0);
            end else begin
                e = sbq.pop_front();
                chk("data", data, e.d);
                chk("blank", blank, e.b);
                chk("data_ok_cycle", cyc, e.at);
                chk("busy_at_ok", busy, 1);
                post_chk = 1;
            end
        end
    end

    task automatic issue(input logic [2:0] l, input logic [15:0] c,
                         input logic [5:0] s);
        @(posedge clk); #1;
        req = 1; layer = l; code = c; sub = s; t_req = cyc;
        @(posedge clk); #1;
        req = 0; layer = 3'd7; code = 16'hFFFF; sub = 6'h00;
    endtask

    task automatic expect_resp(input logic [31:0] d, input logic b,
                               input int lat);
        exp_t e;
        e.d = d; e.b = b; e.at = t_req + lat;
        sbq.push_back(e);
    endtask

    task automatic rom_serve(input logic [21:0] a, input int dly,
                             input logic [31:0] w);
        int n = 0;
        while (!rom_cs && n < 40) begin
            @(posedge clk); #1; n++;
        end
        if (!rom_cs) begin
            chk("rom_cs_wait", 0, 1);
            return;
        end
        chk("rom_addr", rom_addr, a);
        repeat (dly) begin
            @(posedge clk); #1;
            chk("rom_cs_hold", {rom_cs, rom_addr}, {1'b1, a});
        end
        rom_ok = 1; rom_data = w;
        @(posedge clk); #1;
        rom_ok = 0; rom_data = 32'hDEAD_0000;
        chk("rom_cs_drop", rom_cs, 0);
    endtask

    task automatic wait_idle(input bit no_cs);
        bit saw = 0;
        int n = 0;
        do begin
            @(negedge clk);
            saw |= rom_cs;
            n++;
        end while (busy && n < 100);
        if (busy) chk("idle_wait", 1, 0);
        if (no_cs) chk("no_rom_cs", saw, 0);
    endtask

    initial begin
        rst_n = 0; req = 0; layer = 0; code = 0; sub = 0;
        rom_ok = 0; rom_data = 0;
        cfg_off = 0; cfg_mask = 0; cfg_unm = 0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_data_ok", data_ok, 0);
        chk("rst_blank", blank, 0);
        chk("rst_rom_cs", rom_cs, 0);
        chk("rst_map_enable", map_enable, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_data", data, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_map_cin", map_cin, 0);
        chk("rst_map_layer", map_layer, 0);
        @(posedge clk); #1 rst_n = 1;
        repeat (2) @(posedge clk);

        // Mapped fetch: mapped_hi = (3 & 1) | 2 = 3
        cfg_off = 4'h2; cfg_mask = 4'h1; cfg_unm = 0;
        issue(3'd1, 16'h3ABC, 6'h05);
        expect_resp(32'h1234_5678, 0, 9);
        chk("map_enable", map_enable, 1);
        chk("map_cin", map_cin, 10'h0EA);
        chk("map_layer", map_layer, 1);
        rom_serve({4'h3, 12'hABC, 6'h05}, 4, 32'h1234_5678);
        wait_idle(0);

        // Same request again: cache hit
        issue(3'd1, 16'h3ABC, 6'h05);
        expect_resp(32'h1234_5678, 0, 2);
        wait_idle(1);

        // Minimum uncached latency: mapped_hi = (F & C) | 8 = C
        cfg_off = 4'h8; cfg_mask = 4'hC;
        issue(3'd2, 16'hF123, 6'h3F);
        expect_resp(32'hCAFE_F00D, 0, 5);
        rom_serve({4'hC, 12'h123, 6'h3F}, 0, 32'hCAFE_F00D);
        wait_idle(0);

        // Unmapped, then its cached replay
        cfg_unm = 1;
        issue(3'd3, 16'h0456, 6'h10);
        expect_resp(32'h0, 1, 4);
        wait_idle(1);
        issue(3'd3, 16'h0456, 6'h10);
        expect_resp(32'h0, 1, 2);
        wait_idle(1);

        // STARS is never cached, and it evicts the previous entry
        cfg_unm = 0; cfg_off = 4'h0; cfg_mask = 4'hF;
        issue(3'd4, 16'h3ABC, 6'h05);
        expect_resp(32'h0BAD_BEEF, 0, 6);
        rom_serve({4'h3, 12'hABC, 6'h05}, 1, 32'h0BAD_BEEF);
        wait_idle(0);
        issue(3'd4, 16'h3ABC, 6'h05);
        expect_resp(32'h55AA_55AA, 0, 7);
        rom_serve({4'h3, 12'hABC, 6'h05}, 2, 32'h55AA_55AA);
        wait_idle(0);
        cfg_off = 4'h2; cfg_mask = 4'h1;
        issue(3'd1, 16'h3ABC, 6'h05);
        expect_resp(32'h1111_2222, 0, 5);
        rom_serve({4'h3, 12'hABC, 6'h05}, 0, 32'h1111_2222);
        wait_idle(0);

        // Stray rom_ok while idle must do nothing
        @(posedge clk); #1 rom_ok = 1; rom_data = 32'h9999_9999;
        @(posedge clk); #1 rom_ok = 0;
        repeat (3) @(negedge clk);
        chk("stray_rom_ok_busy", busy, 0);

        // Second req two cycles into a transaction is dropped
        cfg_off = 4'h0; cfg_mask = 4'h0;
        issue(3'd1, 16'h0001, 6'h01);
        expect_resp(32'hA5A5_0001, 0, 8);
        fork
            rom_serve({4'h0, 12'h001, 6'h01}, 3, 32'hA5A5_0001);
            begin
                @(posedge clk); #1;
                req = 1; layer = 3'd2; code = 16'h0002; sub = 6'h02;
                @(posedge clk); #1;
                req = 0;
            end
        join
        wait_idle(0);
        repeat (4) @(negedge clk);
        chk("reject_stays_idle", busy, 0);

        // Reset in the middle of FETCH
        issue(3'd2, 16'h0777, 6'h02);
        for (int n = 0; n < 40 && !rom_cs; n++) begin
            @(posedge clk); #1;
        end
        chk("reset_test_cs_up", rom_cs, 1);
        #2 rst_n = 0;
        #1;
        chk("async_rst_rom_cs", rom_cs, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_data_ok", data_ok, 0);
        @(posedge clk); #1 rst_n = 1;
        // The last completed request would have hit; after reset it must not
        issue(3'd1, 16'h0001, 6'h01);
        expect_resp(32'h7E57_AB1E, 0, 5);
        rom_serve({4'h0, 12'h001, 6'h01}, 0, 32'h7E57_AB1E);
        wait_idle(0);

`ifdef JTCPS1_GFX_TIMEOUT_EN
        // No rom_ok: FETCH starts 4 cycles after req, watchdog fires 16 later
        issue(3'd3, 16'h0ABC, 6'h00);
        expect_resp(32'hFFFF_FFFF, 0, 20);
        wait_idle(0);
        chk("timeout_set", timeout, 1);
        issue(3'd3, 16'h0ABD, 6'h01);
        expect_resp(32'h0000_0042, 0, 5);
        rom_serve({4'h0, 12'h0BD, 6'h01}, 0, 32'h0000_0042);
        wait_idle(0);
        chk("timeout_sticky", timeout, 1);
`else
        chk("timeout_tied_low", timeout, 0);
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
